// File: rtl/fu_logic.sv
// Logic functional unit: one of eight bitwise operations on registered operands,
// completing after a configurable latency and holding its result until queued.
module fu_logic #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int TAG_WIDTH  = 7,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  output logic                  idle,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic [TAG_WIDTH-1:0]  executionTag_in,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic [TAG_WIDTH-1:0]  executionTag_out,
  input  logic                  queued
);

  localparam int CNT_W = $clog2(LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  idle_reg_q, idle_reg_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_s;

  // Next-state logic for the dispatch / count / wait-for-queue sequence
  always_comb begin
    state_d    = state_q;
    idle_reg_d = idle_reg_q;
    done_d     = 1'b0;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    opcode_d   = opcode_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ce && idle_reg_q) begin
          op_a_d     = data_0;
          op_b_d     = data_1;
          opcode_d   = opcode;
          tag_d      = executionTag_in;
          cnt_d      = CNT_W'(1);
          idle_reg_d = 1'b0;
          state_d    = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // Counter saturates at LATENCY; the done pulse is issued on the same edge
        if (cnt_q == LAT_C) begin
          done_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (queued) begin
          idle_reg_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        idle_reg_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idle_reg_q <= 1'b1;
      done_q     <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opcode_q   <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idle_reg_q <= idle_reg_d;
      done_q     <= done_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      opcode_q   <= opcode_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
    end
  end

  // Bitwise operation selected by the captured opcode
  always_comb begin
    result_s = '0;
    case (opcode_q)
      3'b000:  result_s = op_a_q & op_b_q;
      3'b001:  result_s = op_a_q | op_b_q;
      3'b010:  result_s = op_a_q ^ op_b_q;
      3'b011:  result_s = ~(op_a_q | op_b_q);
      3'b100:  result_s = op_a_q & ~op_b_q;
      3'b101:  result_s = op_a_q | ~op_b_q;
      3'b110:  result_s = ~(op_a_q ^ op_b_q);
      3'b111:  result_s = op_a_q;
      default: result_s = '0;
    endcase
  end

  // Masking with ce keeps a dispatcher from seeing idle in the cycle it dispatches
  assign idle             = idle_reg_q & ~ce;
  assign done             = done_q;
  assign result           = result_s;
  assign executionTag_out = tag_q;

endmodule

// File: tb/tb_fu_logic.sv
// Bench for fu_logic: three units (latency 1, 3, 4) share stimulus; each is
// compared every cycle against a timestamp-based model, plus directed checks.
module tb_fu_logic;

  localparam int NU = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b0;
  logic queued = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [6:0]  tag_in = 7'd0;
  logic [31:0] d0 = 32'd0;
  logic [31:0] d1 = 32'd0;

  logic [NU-1:0]       done_w, idle_w;
  logic [NU-1:0][31:0] res_w;
  logic [NU-1:0][6:0]  tagout_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    fu_logic #(
      .DATA_WIDTH(32),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .TAG_WIDTH(7),
      .OP_WIDTH(3)
    ) u_dut (
      .clk(clk), .rst(rst), .ce(ce), .idle(idle_w[g]),
      .opcode(opcode), .executionTag_in(tag_in),
      .data_0(d0), .data_1(d1),
      .result(res_w[g]), .done(done_w[g]),
      .executionTag_out(tagout_w[g]), .queued(queued)
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: a unit is free, or owns an op accepted at edge m_acc
  bit          m_free[NU];
  int          m_acc[NU];
  logic [31:0] m_a[NU], m_b[NU];
  logic [2:0]  m_op[NU];
  logic [6:0]  m_tag[NU];

  int          done_at[NU];
  int          done_cnt[NU];
  logic [31:0] res_at[NU];
  logic [6:0]  tag_at[NU];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < NU; k++) begin
      if (rst) begin
        m_free[k] = 1'b1; m_acc[k] = -100;
        m_a[k] = 32'd0; m_b[k] = 32'd0; m_op[k] = 3'd0; m_tag[k] = 7'd0;
      end else if (m_free[k] && ce) begin
        m_free[k] = 1'b0; m_acc[k] = cyc;
        m_a[k] = d0; m_b[k] = d1; m_op[k] = opcode; m_tag[k] = tag_in;
      end else if (!m_free[k] && cyc > m_acc[k] + lat_of(k) && queued) begin
        m_free[k] = 1'b1;
      end
    end
    @(negedge clk);
    for (int k = 0; k < NU; k++) begin
      check_eq($sformatf("u%0d_done", k), 64'(done_w[k]),
               64'(!m_free[k] && cyc == m_acc[k] + lat_of(k)));
      check_eq($sformatf("u%0d_idle", k), 64'(idle_w[k]), 64'(m_free[k] && !ce));
      check_eq($sformatf("u%0d_tag", k), 64'(tagout_w[k]), 64'(m_tag[k]));
      check_eq($sformatf("u%0d_result", k), 64'(res_w[k]), 64'(ref_op(m_a[k], m_b[k], m_op[k])));
      if (done_w[k]) begin
        done_at[k] = cyc; done_cnt[k]++; res_at[k] = res_w[k]; tag_at[k] = tagout_w[k];
      end
    end
    cyc++;
  endtask

  task automatic clear_rec();
    for (int k = 0; k < NU; k++) begin
      done_at[k] = -1; done_cnt[k] = 0; res_at[k] = 32'd0; tag_at[k] = 7'd0;
    end
  endtask

  task automatic dispatch(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [6:0] t);
    d0 = a; d1 = b; opcode = op; tag_in = t; ce = 1'b1;
    cycle();
    ce = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic release_q();
    queued = 1'b1;
    cycle();
    queued = 1'b0;
  endtask

  logic [31:0] sweep_exp[8];
  int e0, e1;

  initial begin
    sweep_exp = '{32'h0204_0608, 32'h1F3F_5F7F, 32'h1D3B_5977, 32'hE0C0_A080,
                  32'h1030_5070, 32'hF2F4_F6F8, 32'hE2C4_A688, 32'h1234_5678};
    for (int k = 0; k < NU; k++) begin
      m_free[k] = 1'b1; m_acc[k] = -100;
      m_a[k] = 32'd0; m_b[k] = 32'd0; m_op[k] = 3'd0; m_tag[k] = 7'd0;
    end
    clear_rec();

    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(1);
    check_eq("reset_idle", 64'(idle_w), 64'(3'b111));
    check_eq("reset_result", 64'(res_w[0]), 64'd0);

    // Test 1: OR with latency 1
    clear_rec(); e0 = cyc;
    dispatch(32'hF0F0_0000, 32'h0FF0_00FF, 3'b001, 7'h15);
    run(5);
    check_eq("t1_lat", 64'(done_at[0] - e0), 64'd1);
    check_eq("t1_result", 64'(res_at[0]), 64'hFFF0_00FF);
    check_eq("t1_tag", 64'(tag_at[0]), 64'h15);
    check_eq("t1_lat4", 64'(done_at[2] - e0), 64'd4);
    check_eq("t1_idle_wait", 64'(idle_w[0]), 64'd0);
    release_q();
    check_eq("t1_idle_after_q", 64'(idle_w), 64'(3'b111));

    // Test 2: XOR with latency 4, queued held low for 10 cycles
    clear_rec(); e0 = cyc;
    dispatch(32'hAAAA_AAAA, 32'hFFFF_0000, 3'b010, 7'h2A);
    run(14);
    check_eq("t2_lat", 64'(done_at[2] - e0), 64'd4);
    check_eq("t2_result", 64'(res_at[2]), 64'h5555_AAAA);
    check_eq("t2_single_done", 64'(done_cnt[2]), 64'd1);
    check_eq("t2_hold_result", 64'(res_w[2]), 64'h5555_AAAA);
    check_eq("t2_hold_tag", 64'(tagout_w[2]), 64'h2A);
    release_q();

    // Test 3: opcode sweep
    for (int op = 0; op < 8; op++) begin
      clear_rec();
      dispatch(32'h1234_5678, 32'h0F0F_0F0F, 3'(op), 7'(op));
      run(4);
      check_eq($sformatf("t3_op%0d", op), 64'(res_at[0]), 64'(sweep_exp[op]));
      check_eq($sformatf("t3_op%0d_l4", op), 64'(res_at[2]), 64'(sweep_exp[op]));
      release_q();
    end

    // Test 4: ce while busy is ignored
    clear_rec();
    dispatch(32'hDEAD_BEEF, 32'h0000_FFFF, 3'b100, 7'h11);
    d0 = 32'h1111_1111; d1 = 32'h2222_2222; opcode = 3'b111; tag_in = 7'h7F; ce = 1'b1;
    run(2);
    ce = 1'b0;
    run(4);
    for (int k = 0; k < NU; k++) begin
      check_eq($sformatf("t4_u%0d_tag", k), 64'(tag_at[k]), 64'h11);
      check_eq($sformatf("t4_u%0d_result", k), 64'(res_at[k]), 64'hDEAD_0000);
      check_eq($sformatf("t4_u%0d_ndone", k), 64'(done_cnt[k]), 64'd1);
    end
    release_q();

    // Test 5: reset one cycle after accept, then a fresh op
    clear_rec();
    dispatch(32'hCAFE_F00D, 32'h1234_4321, 3'b110, 7'h33);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("t5_idle", 64'(idle_w[1]), 64'd1);
    check_eq("t5_tag", 64'(tagout_w[1]), 64'd0);
    check_eq("t5_result", 64'(res_w[1]), 64'd0);
    run(5);
    check_eq("t5_no_done", 64'(done_cnt[1]), 64'd0);
    clear_rec(); e0 = cyc;
    dispatch(32'h0000_00F0, 32'h0000_00FF, 3'b000, 7'h34);
    run(4);
    check_eq("t5_fresh_lat", 64'(done_at[1] - e0), 64'd3);
    check_eq("t5_fresh_result", 64'(res_at[1]), 64'h0000_00F0);
    release_q();

    // rst and ce together: nothing captured
    rst = 1'b1; ce = 1'b1; tag_in = 7'h55;
    cycle();
    rst = 1'b0; ce = 1'b0;
    run(1);
    check_eq("rst_ce_idle", 64'(idle_w), 64'(3'b111));
    check_eq("rst_ce_tag", 64'(tagout_w[0]), 64'd0);

    // Test 6: queued in the done cycle, next dispatch immediately after
    clear_rec(); e0 = cyc;
    dispatch(32'h0000_000F, 32'h0000_00F0, 3'b001, 7'h05);
    cycle();
    queued = 1'b1;
    cycle();
    queued = 1'b0;
    e1 = cyc;
    dispatch(32'h0000_0F00, 32'h0000_F000, 3'b001, 7'h06);
    run(5);
    check_eq("t6_ndone", 64'(done_cnt[0]), 64'd2);
    check_eq("t6_lat2", 64'(done_at[0] - e1), 64'd1);
    check_eq("t6_tag2", 64'(tag_at[0]), 64'h06);
    check_eq("t6_result2", 64'(res_at[0]), 64'h0000_FF00);
    release_q();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      ce     = ($urandom_range(0, 2) == 0);
      queued = ($urandom_range(0, 2) == 0);
      d0     = $urandom;
      d1     = $urandom;
      opcode = 3'($urandom_range(0, 7));
      tag_in = 7'($urandom_range(0, 127));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
